// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO between the PDM mic front end and the CPU CSR bank.
// First-word-fall-through head, explicit level counter, sticky error flags and a watermark irq.
module pcm_sample_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int EDGE_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ack,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    input  logic [DEPTH_LOG2:0]   threshold,
    input  logic                  irq_enable,
    input  logic                  flush,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clear,
    output logic [15:0]           drop_count,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  vld_hist_q, vld_hist_d;
    logic                  in_ack_q, in_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [15:0]           drop_q, drop_d;
    logic                  irq_q, irq_d;

    logic is_empty, is_full, push_ev, pop, wr_en, drop_ev, uf_ev, thr_hit;

    always_comb begin
        is_empty = (level_q == '0);
        is_full  = (level_q == LVL_W'(DEPTH));
        push_ev  = enable & in_valid & ((EDGE_DETECT != 0) ? ~vld_hist_q : 1'b1);
        pop      = rd_en & ~is_empty & ~flush;
        uf_ev    = rd_en & is_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        wr_en    = push_ev & ~flush & (~is_full | pop);
        drop_ev  = push_ev & ~flush & is_full & ~pop;
        thr_hit  = (threshold != '0) && (level_q >= threshold);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        vld_hist_d  = in_valid;
        in_ack_d    = push_ev;
        irq_d       = irq_enable & (thr_hit | overflow_q);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // A new error event in the clearing cycle takes precedence over the clear.
        overflow_d  = (overflow_q & ~err_clear) | drop_ev;
        underflow_d = (underflow_q & ~err_clear) | uf_ev;
        if (err_clear) begin
            drop_d = drop_ev ? 16'd1 : 16'd0;
        end else if (drop_ev && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            vld_hist_q  <= 1'b1;
            in_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            vld_hist_q  <= vld_hist_d;
            in_ack_q    <= in_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
            irq_q       <= irq_d;
        end
    end

    // Storage is left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign in_ack     = in_ack_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign drop_count = drop_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Scoreboard bench for pcm_sample_fifo: stimulus queues expected head samples, a negedge monitor checks pops.
module tb_pcm_sample_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_valid_b = 1'b0;
    logic [15:0] in_data = '0;
    logic        rd_en = 1'b0;
    logic        rd_en_b = 1'b0;
    logic [8:0]  threshold = '0;
    logic        irq_enable = 1'b0;
    logic        flush = 1'b0;
    logic        err_clear = 1'b0;

    logic        in_ack, empty, full, overflow, underflow, irq;
    logic [15:0] rd_data, drop_count;
    logic [8:0]  level;

    logic        b_in_ack, b_empty, b_full, b_overflow, b_underflow, b_irq;
    logic [15:0] b_rd_data, b_drop_count;
    logic [8:0]  b_level;

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;
    int exp_ack = 0;
    logic [15:0] exp_q[$];

    pcm_sample_fifo #(.DATA_W(16), .DEPTH_LOG2(8), .EDGE_DETECT(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ack(in_ack), .rd_en(rd_en), .rd_data(rd_data), .level(level), .empty(empty),
        .full(full), .threshold(threshold), .irq_enable(irq_enable), .flush(flush),
        .overflow(overflow), .underflow(underflow), .err_clear(err_clear),
        .drop_count(drop_count), .irq(irq)
    );

    pcm_sample_fifo #(.DATA_W(16), .DEPTH_LOG2(8), .EDGE_DETECT(0)) u_dut_lvl (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid_b), .in_data(in_data),
        .in_ack(b_in_ack), .rd_en(rd_en_b), .rd_data(b_rd_data), .level(b_level), .empty(b_empty),
        .full(b_full), .threshold(threshold), .irq_enable(irq_enable), .flush(flush),
        .overflow(b_overflow), .underflow(b_underflow), .err_clear(err_clear),
        .drop_count(b_drop_count), .irq(b_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            if (in_ack) ack_seen++;
            if (rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_data: got %0h expected nothing", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", {16'h0, rd_data}, {16'h0, e});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input bit expect_head);
        if (expect_head) exp_q.push_back(d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        exp_ack++;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_in_ack"}, 32'(in_ack), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_underflow"}, 32'(underflow), 0);
        check({tag, "_drop_count"}, 32'(drop_count), 0);
        check({tag, "_irq"}, 32'(irq), 0);
    endtask

    initial begin
        // Reset with in_valid already high: no push once reset releases.
        in_valid = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) tick();
        check("no_push_after_reset", 32'(level), 0);
        check("no_ack_after_reset", 32'(in_ack), 0);
        in_valid = 1'b0;
        tick();

        // Three samples in, three out.
        push(16'h0001, 1'b1);
        push(16'h0002, 1'b1);
        push(16'h0003, 1'b1);
        check("basic_level", 32'(level), 3);
        check("basic_head", 32'(rd_data), 32'h0001);
        check("basic_acks", ack_seen, 3);
        repeat (3) pop();
        check("basic_empty", 32'(empty), 1);

        // Held in_valid: one push with edge detect, ten without.
        in_data    = 16'h00AA;
        exp_q.push_back(16'h00AA);
        in_valid   = 1'b1;
        in_valid_b = 1'b1;
        repeat (10) tick();
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        tick();
        exp_ack++;
        check("edge_level", 32'(level), 1);
        check("lvl_mode_level", 32'(b_level), 10);
        pop();

        // Fill to full, then overflow by five; irq via overflow with threshold 0.
        threshold  = '0;
        irq_enable = 1'b1;
        for (int i = 0; i < 256; i++) push(16'h1000 + 16'(i), 1'b1);
        check("fill_full", 32'(full), 1);
        check("fill_irq_thr0", 32'(irq), 0);
        repeat (5) push(16'hDEAD, 1'b0);
        check("ovf_full", 32'(full), 1);
        check("ovf_level", 32'(level), 256);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drops", 32'(drop_count), 5);
        check("ovf_head", 32'(rd_data), 32'h1000);
        check("ovf_irq", 32'(irq), 1);
        check("ovf_acks", ack_seen, exp_ack);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_overflow", 32'(overflow), 0);
        check("clr_underflow", 32'(underflow), 0);
        check("clr_drops", 32'(drop_count), 0);
        tick();
        check("clr_irq", 32'(irq), 0);

        // Push and pop together while full.
        irq_enable = 1'b0;
        in_data    = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        in_valid   = 1'b1;
        rd_en      = 1'b1;
        tick();
        in_valid   = 1'b0;
        rd_en      = 1'b0;
        exp_ack++;
        check("pp_level", 32'(level), 256);
        check("pp_overflow", 32'(overflow), 0);
        tick();
        repeat (256) pop();
        check("drain_empty", 32'(empty), 1);
        check("drain_scoreboard", exp_q.size(), 0);

        // Watermark irq at threshold 4.
        threshold  = 9'd4;
        irq_enable = 1'b1;
        push(16'h0040, 1'b1);
        push(16'h0041, 1'b1);
        push(16'h0042, 1'b1);
        check("wm_irq_below", 32'(irq), 0);
        exp_q.push_back(16'h0043);
        in_data  = 16'h0043;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_ack++;
        check("wm_level4", 32'(level), 4);
        check("wm_irq_lag", 32'(irq), 0);
        tick();
        check("wm_irq_set", 32'(irq), 1);
        pop();
        check("wm_irq_hold", 32'(irq), 1);
        tick();
        check("wm_irq_clear", 32'(irq), 0);
        threshold = '0;
        push(16'h0044, 1'b1);
        tick();
        check("wm_thr0_irq", 32'(irq), 0);
        repeat (4) pop();
        check("wm_empty", 32'(empty), 1);

        // Underflow, then flush with a simultaneous push.
        irq_enable = 1'b0;
        pop();
        check("uf_flag", 32'(underflow), 1);
        check("uf_level", 32'(level), 0);
        for (int i = 0; i < 7; i++) push(16'h0070 + 16'(i), 1'b0);
        check("fl_pre_level", 32'(level), 7);
        in_data  = 16'h7777;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_ack++;
        check("fl_ack", 32'(in_ack), 1);
        check("fl_level", 32'(level), 0);
        check("fl_empty", 32'(empty), 1);
        check("fl_overflow", 32'(overflow), 0);
        check("fl_underflow_sticky", 32'(underflow), 1);
        tick();

        // Disabled input is ignored.
        enable   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        enable   = 1'b1;
        check("dis_level", 32'(level), 0);
        check("dis_acks", ack_seen, exp_ack);

        // Reset in the middle of filling.
        threshold  = 9'd2;
        irq_enable = 1'b1;
        repeat (3) push(16'h0099, 1'b0);
        tick();
        check("mid_irq_pre", 32'(irq), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        check("final_scoreboard", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
